matvec_ntt_mac: RTL and testbench

//  Consumer of the packed matrix A produced by ExpandA. Computes w_hat = A_hat * s1_hat in the NTT domain.
//  Per row i: w_hat[i][n] = sum_{j<L} A[i][j][n] * s1[j][n] mod Q, for n = 0..N-1.

---
 rtl/matvec_ntt_mac.sv | 266 ++++++++++++++++++++++++++
 tb/tb_matvec_ntt_mac.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_ntt_mac.sv
// matvec_ntt_mac: streams A_hat and s1_hat words from NTT BRAM and writes w_hat = A_hat * s1_hat mod Q.
// Optional input range flag: define MATVEC_RANGE_CHECK_EN (otherwise err_range is tied low).
module matvec_ntt_mac #(
    parameter int K                    = 8,
    parameter int L                    = 7,
    parameter int N                    = 256,
    parameter int Q                    = 8380417,
    parameter int COEFF_WIDTH          = 24,
    parameter int COEFF_PER_WORD       = 4,
    parameter int WORD_COEFF           = COEFF_WIDTH * COEFF_PER_WORD,
    parameter int NTT_ADDR_WIDTH       = 12,
    parameter int MATRIX_A_BASE_OFFSET = 0,
    parameter int S1_BASE_OFFSET       = 3584,
    parameter int W_BASE_OFFSET        = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [NTT_ADDR_WIDTH-1:0] addr_matA,
    input  logic [WORD_COEFF-1:0]     dout_matA,
    output logic [NTT_ADDR_WIDTH-1:0] addr_s1,
    input  logic [WORD_COEFF-1:0]     dout_s1,
    output logic                      we_w,
    output logic [NTT_ADDR_WIDTH-1:0] addr_w,
    output logic [WORD_COEFF-1:0]     din_w,
    output logic                      err_range
);

    localparam int W   = N / COEFF_PER_WORD;
    localparam int IW  = $clog2(K);
    localparam int JW  = $clog2(L);
    localparam int WW  = $clog2(W);
    localparam int AW  = NTT_ADDR_WIDTH;
    localparam int CPW = COEFF_PER_WORD;
    localparam logic [23:0] Q24 = 24'(Q);

    // state   | meaning
    // IDLE    | waiting for start
    // RUN     | one A/s1 read pair issued per cycle
    // DRAIN   | waiting for the pipeline to empty
    // DONE    | one-cycle done pulse
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [WW-1:0] w_q, w_d;
    logic [JW-1:0] j_q, j_d;
    logic [AW-1:0] addr_a_q, addr_a_d, addr_s1_q, addr_s1_d;

    logic          v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
    logic [AW-1:0] wa1_q, wa1_d;
    logic          v2_q, v2_d, first2_q, first2_d, last2_q, last2_d;
    logic [AW-1:0] wa2_q, wa2_d;
    logic [CPW-1:0][45:0] prod_q, prod_d;
    logic          v3_q, v3_d, first3_q, first3_d, last3_q, last3_d;
    logic [AW-1:0] wa3_q, wa3_d;
    logic [CPW-1:0][22:0] red_q, red_d;
    logic          v4_q, v4_d, last4_q, last4_d;
    logic [AW-1:0] wa4_q, wa4_d;
    logic [CPW-1:0][22:0] acc_q, acc_d;
    logic [CPW-1:0][23:0] sum_c;
    logic          we_q, we_d;
    logic [AW-1:0] addr_w_q, addr_w_d;
    logic [WORD_COEFF-1:0] din_q, din_d;
    logic          last_issue;

    // Three folds using 2^23 == 2^13 - 1 (mod Q) bring a 46-bit product below 2Q.
    function automatic logic [22:0] mod_q(input logic [45:0] x);
        logic [36:0] y;
        logic [27:0] z;
        logic [23:0] u;
        y = 37'(x[45:23]) * 37'd8191 + 37'(x[22:0]);
        z = 28'(y[36:23]) * 28'd8191 + 28'(y[22:0]);
        u = 24'(z[27:23]) * 24'd8191 + 24'(z[22:0]);
        if (u >= Q24) u = u - Q24;
        return u[22:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        w_d        = w_q;
        j_d        = j_q;
        addr_a_d   = addr_a_q;
        addr_s1_d  = addr_s1_q;
        last_issue = (state_q == S_RUN) && (i_q == IW'(K - 1)) && (w_q == WW'(W - 1))
                     && (j_q == JW'(L - 1));
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    i_d     = '0;
                    w_d     = '0;
                    j_d     = '0;
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end else if (j_q == JW'(L - 1)) begin
                    j_d = '0;
                    if (w_q == WW'(W - 1)) begin
                        w_d = '0;
                        i_d = i_q + IW'(1);
                    end else begin
                        w_d = w_q + WW'(1);
                    end
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            S_DRAIN: if (!(v1_q || v2_q || v3_q || v4_q)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Addresses are registered so they sit at 0 out of reset until the first start.
        if (state_d == S_RUN) begin
            addr_a_d  = AW'(MATRIX_A_BASE_OFFSET + (int'(i_d) * L + int'(j_d)) * W + int'(w_d));
            addr_s1_d = AW'(S1_BASE_OFFSET + int'(j_d) * W + int'(w_d));
        end

        v1_d     = (state_q == S_RUN);
        first1_d = (j_q == '0);
        last1_d  = (j_q == JW'(L - 1));
        wa1_d    = AW'(W_BASE_OFFSET + int'(i_q) * W + int'(w_q));

        v2_d     = v1_q;
        first2_d = first1_q;
        last2_d  = last1_q;
        wa2_d    = wa1_q;
        v3_d     = v2_q;
        first3_d = first2_q;
        last3_d  = last2_q;
        wa3_d    = wa2_q;
        v4_d     = v3_q;
        last4_d  = last3_q;
        wa4_d    = wa3_q;
        acc_d    = acc_q;
        sum_c    = '0;
        for (int k = 0; k < CPW; k++) begin
            prod_d[k] = 46'(dout_matA[k*COEFF_WIDTH +: 23]) * 46'(dout_s1[k*COEFF_WIDTH +: 23]);
            red_d[k]  = mod_q(prod_q[k]);
            sum_c[k]  = {1'b0, acc_q[k]} + {1'b0, red_q[k]};
            if (v3_q) begin
                if (first3_q)            acc_d[k] = red_q[k];
                else if (sum_c[k] >= Q24) acc_d[k] = 23'(sum_c[k] - Q24);
                else                      acc_d[k] = sum_c[k][22:0];
            end
        end

        we_d     = v4_q && last4_q;
        addr_w_d = addr_w_q;
        din_d    = din_q;
        if (we_d) begin
            addr_w_d = wa4_q;
            for (int k = 0; k < CPW; k++) din_d[k*COEFF_WIDTH +: COEFF_WIDTH] = COEFF_WIDTH'(acc_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            w_q       <= '0;
            j_q       <= '0;
            addr_a_q  <= '0;
            addr_s1_q <= '0;
            v1_q      <= 1'b0;
            first1_q  <= 1'b0;
            last1_q   <= 1'b0;
            wa1_q     <= '0;
            v2_q      <= 1'b0;
            first2_q  <= 1'b0;
            last2_q   <= 1'b0;
            wa2_q     <= '0;
            prod_q    <= '0;
            v3_q      <= 1'b0;
            first3_q  <= 1'b0;
            last3_q   <= 1'b0;
            wa3_q     <= '0;
            red_q     <= '0;
            v4_q      <= 1'b0;
            last4_q   <= 1'b0;
            wa4_q     <= '0;
            acc_q     <= '0;
            we_q      <= 1'b0;
            addr_w_q  <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            w_q       <= w_d;
            j_q       <= j_d;
            addr_a_q  <= addr_a_d;
            addr_s1_q <= addr_s1_d;
            v1_q      <= v1_d;
            first1_q  <= first1_d;
            last1_q   <= last1_d;
            wa1_q     <= wa1_d;
            v2_q      <= v2_d;
            first2_q  <= first2_d;
            last2_q   <= last2_d;
            wa2_q     <= wa2_d;
            prod_q    <= prod_d;
            v3_q      <= v3_d;
            first3_q  <= first3_d;
            last3_q   <= last3_d;
            wa3_q     <= wa3_d;
            red_q     <= red_d;
            v4_q      <= v4_d;
            last4_q   <= last4_d;
            wa4_q     <= wa4_d;
            acc_q     <= acc_d;
            we_q      <= we_d;
            addr_w_q  <= addr_w_d;
            din_q     <= din_d;
        end
    end

`ifdef MATVEC_RANGE_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && start) begin
            err_d = 1'b0;
        end else if (v1_q) begin
            for (int k = 0; k < CPW; k++) begin
                if (dout_matA[k*COEFF_WIDTH +: 24] >= Q24 || dout_s1[k*COEFF_WIDTH +: 24] >= Q24)
                    err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err_range = err_q;
`else
    logic unused_msb;

    always_comb begin
        unused_msb = 1'b0;
        for (int k = 0; k < CPW; k++)
            unused_msb = unused_msb ^ dout_matA[k*COEFF_WIDTH + 23] ^ dout_s1[k*COEFF_WIDTH + 23];
    end

    assign err_range = 1'b0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign addr_matA = addr_a_q;
    assign addr_s1   = addr_s1_q;
    assign we_w      = we_q;
    assign addr_w    = addr_w_q;
    assign din_w     = din_q;

endmodule

// File: tb/tb_matvec_ntt_mac.sv
// Testbench for matvec_ntt_mac: BRAM models, coefficient-level reference model, table and sequence checks.
module tb_matvec_ntt_mac;

    localparam int K = 8;
    localparam int L = 7;
    localparam int N = 256;
    localparam int W = 64;
    localparam longint Q = 8380417;
    localparam int DONE_REL = K * W * L + 6;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [11:0] addr_matA;
    logic [95:0] dout_matA;
    logic [11:0] addr_s1;
    logic [95:0] dout_s1;
    logic        we_w;
    logic [11:0] addr_w;
    logic [95:0] din_w;
    logic        err_range;

    matvec_ntt_mac dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .addr_matA(addr_matA), .dout_matA(dout_matA),
        .addr_s1(addr_s1), .dout_s1(dout_s1),
        .we_w(we_w), .addr_w(addr_w), .din_w(din_w), .err_range(err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [95:0] mem_a  [4096];
    logic [95:0] mem_s1 [4096];
    always @(posedge clk) begin
        dout_matA <= mem_a[addr_matA];
        dout_s1   <= mem_s1[addr_s1];
    end

    typedef struct {
        logic [11:0] addr;
        logic [95:0] data;
        int          cyc;
    } wr_t;
    wr_t wq[$];
    always @(negedge clk) if (we_w) wq.push_back('{addr_w, din_w, cyc});

    typedef struct {
        logic [23:0] a_val;
        logic [23:0] s_val;
        logic [23:0] exp_coeff;
    } vec_t;
    vec_t tbl[4];

    logic [23:0] a_c [K][L][N];
    logic [23:0] s_c [L][N];

    int checks = 0;
    int errors = 0;
    bit prev_err = 1'b0;

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic load_mem();
        for (int a = 0; a < 4096; a++) begin
            mem_a[a]  = '0;
            mem_s1[a] = '0;
        end
        for (int i = 0; i < K; i++)
            for (int j = 0; j < L; j++)
                for (int w = 0; w < W; w++)
                    for (int k = 0; k < 4; k++)
                        mem_a[i*L*W + j*W + w][k*24 +: 24] = a_c[i][j][4*w+k];
        for (int j = 0; j < L; j++)
            for (int w = 0; w < W; w++)
                for (int k = 0; k < 4; k++)
                    mem_s1[3584 + j*W + w][k*24 +: 24] = s_c[j][4*w+k];
    endtask

    task automatic fill_uniform(input logic [23:0] av, input logic [23:0] sv);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < L; j++)
                for (int n = 0; n < N; n++) a_c[i][j][n] = av;
        for (int j = 0; j < L; j++)
            for (int n = 0; n < N; n++) s_c[j][n] = sv;
    endtask

    task automatic fill_random();
        for (int i = 0; i < K; i++)
            for (int j = 0; j < L; j++)
                for (int n = 0; n < N; n++) a_c[i][j][n] = 24'($urandom());
        for (int j = 0; j < L; j++)
            for (int n = 0; n < N; n++) s_c[j][n] = 24'($urandom());
    endtask

    function automatic logic [95:0] model_word(input int i, input int w);
        logic [95:0] r;
        longint acc;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int j = 0; j < L; j++)
                acc += longint'(a_c[i][j][4*w+k] & 24'h7FFFFF) * longint'(s_c[j][4*w+k] & 24'h7FFFFF);
            r[k*24 +: 24] = 24'(acc % Q);
        end
        return r;
    endfunction

    function automatic bit model_err();
`ifdef MATVEC_RANGE_CHECK_EN
        for (int i = 0; i < K; i++)
            for (int j = 0; j < L; j++)
                for (int n = 0; n < N; n++) if (longint'(a_c[i][j][n]) >= Q) return 1'b1;
        for (int j = 0; j < L; j++)
            for (int n = 0; n < N; n++) if (longint'(s_c[j][n]) >= Q) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic chk_reset_vals(input string nm);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " done"}, done, 0);
        chk({nm, " we_w"}, we_w, 0);
        chk({nm, " addr_matA"}, addr_matA, 0);
        chk({nm, " addr_s1"}, addr_s1, 0);
        chk({nm, " addr_w"}, addr_w, 0);
        chk({nm, " din_w"}, din_w, 0);
        chk({nm, " err_range"}, err_range, 0);
    endtask

    task automatic do_run(input string nm, input bit use_uni, input logic [23:0] uni);
        int c0;
        int rel;
        bit exp_err;
        logic [95:0] exp_word;
        load_mem();
        exp_err = model_err();
        wq.delete();
        @(negedge clk);
        chk({nm, " err_before_start"}, err_range, prev_err);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy_cycle1"}, busy, 1);
        rel = cyc - c0;
        while (!done && rel < 5000) begin
            @(negedge clk);
            rel = cyc - c0;
            start = (rel == 100 || rel == DONE_REL - 3);
            if (rel == 2) chk({nm, " err_cleared"}, err_range, 0);
        end
        start = 1'b0;
        if (!done) begin
            chk({nm, " done_timeout"}, 0, 1);
            return;
        end
        chk({nm, " done_cycle"}, 96'(rel), 96'(DONE_REL));
        chk({nm, " busy_at_done"}, busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy_after_done"}, busy, 0);
        chk({nm, " done_pulse"}, done, 0);
        chk({nm, " err_range"}, err_range, exp_err);
        prev_err = exp_err;
        chk({nm, " write_count"}, 96'(wq.size()), 96'(K * W));
        for (int k = 0; k < wq.size() && k < K * W; k++) begin
            exp_word = use_uni ? {4{uni}} : model_word(k / W, k % W);
            chk($sformatf("%s addr[%0d]", nm, k), wq[k].addr, 96'(k));
            chk($sformatf("%s wcyc[%0d]", nm, k), 96'(wq[k].cyc - c0), 96'(12 + 7 * k));
            chk($sformatf("%s data[%0d]", nm, k), wq[k].data, exp_word);
        end
    endtask

    initial begin
        int c0;
        int n_before;
        tbl[0] = '{24'd1, 24'd1, 24'd7};
        tbl[1] = '{24'd8380416, 24'd8380416, 24'd7};
        tbl[2] = '{24'd8380416, 24'd1, 24'd8380410};
        tbl[3] = '{24'd2, 24'd3, 24'd42};

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        for (int t = 0; t < 4; t++) begin
            fill_uniform(tbl[t].a_val, tbl[t].s_val);
            do_run($sformatf("uni%0d", t), 1'b1, tbl[t].exp_coeff);
        end

        for (int i = 0; i < K; i++)
            for (int j = 0; j < L; j++)
                for (int n = 0; n < N; n++) a_c[i][j][n] = 24'(i + 1);
        for (int j = 0; j < L; j++)
            for (int n = 0; n < N; n++) s_c[j][n] = 24'(n);
        do_run("pattern", 1'b0, '0);
        if (wq.size() > 3 * W + 63) chk("w3_255", wq[3*W+63].data[95:72], 7140);
        else chk("w3_255 missing", 0, 1);

        fill_random();
        do_run("random", 1'b0, '0);

        // Abort a run with rst at cycle 1000, then rerun from scratch.
        fill_uniform(24'd5, 24'd9);
        load_mem();
        wq.delete();
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc - c0 < 1000) @(negedge clk);
        rst = 1'b1;
        n_before = wq.size();
        @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst writes_before", 96'(n_before), 96'(142));
        chk("midrst no_writes_after", 96'(wq.size()), 96'(n_before));
        chk("midrst idle", busy, 0);
        prev_err = 1'b0;
        fill_random();
        do_run("after_rst", 1'b0, '0);

        fill_uniform(24'd1, 24'd1);
        s_c[2][5] = 24'hFFFFFF;
        do_run("range_bad", 1'b0, '0);
        s_c[2][5] = 24'd1;
        do_run("range_clean", 1'b1, 24'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
